// File: rtl/main_dec_pipe.sv
// rtl/main_dec_pipe.sv - MIPS32 main decoder stage with registered output and mul/div busy tracking.
// Build option MAIN_DEC_RI_EXC_EN: flag undefined encodings on ri_exc instead of tying it to 0.
module main_dec_pipe #(
   parameter int CTRL_W  = 10,
   parameter int ALUOP_W = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [31:0]        inst,
   output logic               in_ready,
   input  logic               flush,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [CTRL_W-1:0]  ctrl,
   output logic [ALUOP_W-1:0] aluop,
   output logic               md_busy,
   output logic               ri_exc
);

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;

   localparam logic [5:0] F_SLL     = 6'b000000;
   localparam logic [5:0] F_SRL     = 6'b000010;
   localparam logic [5:0] F_SRA     = 6'b000011;
   localparam logic [5:0] F_SLLV    = 6'b000100;
   localparam logic [5:0] F_SRLV    = 6'b000110;
   localparam logic [5:0] F_SRAV    = 6'b000111;
   localparam logic [5:0] F_MFHI    = 6'b010000;
   localparam logic [5:0] F_MFLO    = 6'b010010;
   localparam logic [5:0] F_MULT    = 6'b011000;
   localparam logic [5:0] F_MULTU   = 6'b011001;
   localparam logic [5:0] F_DIV     = 6'b011010;
   localparam logic [5:0] F_DIVU    = 6'b011011;
   localparam logic [5:0] F_ADD     = 6'b100000;
   localparam logic [5:0] F_ADDU    = 6'b100001;
   localparam logic [5:0] F_SUB     = 6'b100010;
   localparam logic [5:0] F_SUBU    = 6'b100011;
   localparam logic [5:0] F_AND     = 6'b100100;
   localparam logic [5:0] F_OR      = 6'b100101;
   localparam logic [5:0] F_XOR     = 6'b100110;
   localparam logic [5:0] F_NOR     = 6'b100111;
   localparam logic [5:0] F_SLT     = 6'b101010;
   localparam logic [5:0] F_SLTU    = 6'b101011;

   localparam logic [3:0] ALUOP_NOP   = 4'd0;
   localparam logic [3:0] ALUOP_RTYPE = 4'd1;
   localparam logic [3:0] ALUOP_ADD   = 4'd2;
   localparam logic [3:0] ALUOP_SUB   = 4'd3;
   localparam logic [3:0] ALUOP_AND   = 4'd4;
   localparam logic [3:0] ALUOP_OR    = 4'd5;
   localparam logic [3:0] ALUOP_XOR   = 4'd6;
   localparam logic [3:0] ALUOP_LUI   = 4'd7;
   localparam logic [3:0] ALUOP_SLT   = 4'd8;
   localparam logic [3:0] ALUOP_SLTU  = 4'd9;
   localparam logic [3:0] ALUOP_ADDU  = 4'd10;

   // {hilowrite, jump, branch, alusrc, memwrite, memtoreg, regwrite, regdst, hiloread, mdstart}
   localparam logic [9:0] INST_CON_RTYPE  = 10'b00_0000_1100;
   localparam logic [9:0] INST_CON_MULDIV = 10'b10_0000_0001;
   localparam logic [9:0] INST_CON_MFHILO = 10'b00_0000_1110;
   localparam logic [9:0] INST_CON_IMM    = 10'b00_0100_1000;
   localparam logic [9:0] INST_CON_LW     = 10'b00_0101_1000;
   localparam logic [9:0] INST_CON_SW     = 10'b00_0110_0000;
   localparam logic [9:0] INST_CON_BRANCH = 10'b00_1000_0000;
   localparam logic [9:0] INST_CON_J      = 10'b01_0000_0000;

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rt;
   logic [9:0] dec_ctrl;
   logic [3:0] dec_aluop;
   logic       dec_undef;
   logic       hazard;
   logic       stage_free;
   logic       accept;
   logic [7:0] busy_cnt;
   logic [7:0] md_lat;

   assign op    = inst[31:26];
   assign funct = inst[5:0];
   assign rt    = inst[20:16];

   always_comb begin
      dec_ctrl  = '0;
      dec_aluop = ALUOP_NOP;
      dec_undef = 1'b0;
      unique case (op)
         OP_RTYPE: begin
            unique case (funct)
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
                  dec_ctrl  = INST_CON_RTYPE;
                  dec_aluop = ALUOP_RTYPE;
               end
               F_MFHI, F_MFLO: begin
                  dec_ctrl  = INST_CON_MFHILO;
                  dec_aluop = ALUOP_RTYPE;
               end
               F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                  dec_ctrl  = INST_CON_MULDIV;
                  dec_aluop = ALUOP_RTYPE;
               end
               default: dec_undef = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            if (rt == RT_BLTZ || rt == RT_BGEZ) begin
               dec_ctrl  = INST_CON_BRANCH;
               dec_aluop = ALUOP_SUB;
            end else begin
               dec_undef = 1'b1;
            end
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
            dec_ctrl  = INST_CON_BRANCH;
            dec_aluop = ALUOP_SUB;
         end
         OP_J: begin
            dec_ctrl  = INST_CON_J;
            dec_aluop = ALUOP_NOP;
         end
         OP_ADDI:  begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_ADD;  end
         OP_ADDIU: begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_ADDU; end
         OP_SLTI:  begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_SLT;  end
         OP_SLTIU: begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_SLTU; end
         OP_ANDI:  begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_AND;  end
         OP_ORI:   begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_OR;   end
         OP_XORI:  begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_XOR;  end
         OP_LUI:   begin dec_ctrl = INST_CON_IMM; dec_aluop = ALUOP_LUI;  end
         OP_LW:    begin dec_ctrl = INST_CON_LW;  dec_aluop = ALUOP_ADD;  end
         OP_SW:    begin dec_ctrl = INST_CON_SW;  dec_aluop = ALUOP_ADD;  end
         default:  dec_undef = 1'b1;
      endcase
   end

   // A second mul/div op or a HI/LO read must wait until the unit drains.
   assign hazard     = md_busy & (dec_ctrl[1] | dec_ctrl[0]);
   assign stage_free = ~out_valid | out_ready;
   assign in_ready   = stage_free & ~flush & ~hazard;
   assign accept     = in_valid & in_ready;
   assign md_lat     = (funct == F_DIV || funct == F_DIVU) ? 8'(DIV_LAT) : 8'(MUL_LAT);
   assign md_busy    = (busy_cnt != 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         ctrl      <= '0;
         aluop     <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         ctrl      <= CTRL_W'(dec_ctrl);
         aluop     <= ALUOP_W'(dec_aluop);
      end else if (out_ready || flush) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= 8'd0;
      end else if (accept && dec_ctrl[0]) begin
         busy_cnt <= md_lat;
      end else if (busy_cnt != 8'd0) begin
         busy_cnt <= busy_cnt - 8'd1;
      end
   end

`ifdef MAIN_DEC_RI_EXC_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ri_exc <= 1'b0;
      end else if (accept) begin
         ri_exc <= dec_undef;
      end
   end

   logic unused_inst;
   assign unused_inst = ^{inst[25:21], inst[15:6]};
`else
   assign ri_exc = 1'b0;

   logic unused_inst;
   assign unused_inst = ^{inst[25:21], inst[15:6], dec_undef};
`endif

endmodule

// File: tb/tb_main_dec_pipe.sv
// tb/tb_main_dec_pipe.sv - table-driven and sequence checks for main_dec_pipe.
module tb_main_dec_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] inst;
   logic        in_ready;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [9:0]  ctrl;
   logic [3:0]  aluop;
   logic        md_busy;
   logic        ri_exc;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef MAIN_DEC_RI_EXC_EN
   localparam bit RI_ON = 1'b1;
`else
   localparam bit RI_ON = 1'b0;
`endif

   localparam logic [31:0] I_LW    = 32'h8C00_0000;
   localparam logic [31:0] I_ORI   = 32'h3400_0000;
   localparam logic [31:0] I_ADD   = 32'h0000_0020;
   localparam logic [31:0] I_MULT  = 32'h0000_0018;
   localparam logic [31:0] I_DIV   = 32'h0000_001A;
   localparam logic [31:0] I_MFHI  = 32'h0000_0010;
   localparam logic [31:0] I_MFLO  = 32'h0000_0012;

   main_dec_pipe #(.CTRL_W(10), .ALUOP_W(4), .MUL_LAT(4), .DIV_LAT(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .inst      (inst),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .ctrl      (ctrl),
      .aluop     (aluop),
      .md_busy   (md_busy),
      .ri_exc    (ri_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic [9:0]  ctrl;
      logic [3:0]  aluop;
      logic        ri;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Offer one instruction from the next falling edge, waiting out hazards, then take the handshake edge.
   task automatic issue(input string nm, input logic [31:0] i);
      int n = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      inst      = i;
      out_ready = 1'b1;
      flush     = 1'b0;
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({nm, "_accept"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      int cnt;

      tbl[0]  = '{"lw",       I_LW,          10'h058, 4'd2,  1'b0};
      tbl[1]  = '{"sw",       32'hAC00_0000, 10'h060, 4'd2,  1'b0};
      tbl[2]  = '{"add",      I_ADD,         10'h00C, 4'd1,  1'b0};
      tbl[3]  = '{"ori",      I_ORI,         10'h048, 4'd5,  1'b0};
      tbl[4]  = '{"lui",      32'h3C00_0000, 10'h048, 4'd7,  1'b0};
      tbl[5]  = '{"slti",     32'h2800_0000, 10'h048, 4'd8,  1'b0};
      tbl[6]  = '{"addiu",    32'h2400_0000, 10'h048, 4'd10, 1'b0};
      tbl[7]  = '{"beq",      32'h1000_0000, 10'h080, 4'd3,  1'b0};
      tbl[8]  = '{"bgez",     32'h0401_0000, 10'h080, 4'd3,  1'b0};
      tbl[9]  = '{"j",        32'h0800_0000, 10'h100, 4'd0,  1'b0};
      tbl[10] = '{"mult",     I_MULT,        10'h201, 4'd1,  1'b0};
      tbl[11] = '{"mfhi",     I_MFHI,        10'h00E, 4'd1,  1'b0};
      tbl[12] = '{"bad_op",   32'hFC00_0000, 10'h000, 4'd0,  1'b1};
      tbl[13] = '{"bad_fn",   32'h0000_003F, 10'h000, 4'd0,  1'b1};
      tbl[14] = '{"bad_rt",   32'h0402_0000, 10'h000, 4'd0,  1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      inst      = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_md_busy",   32'(md_busy),   32'd0);
      check("rst_ctrl",      32'(ctrl),      32'd0);
      check("rst_aluop",     32'(aluop),     32'd0);
      check("rst_ri_exc",    32'(ri_exc),    32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 15; k++) begin
         issue(tbl[k].name, tbl[k].inst);
         check({tbl[k].name, "_out_valid"}, 32'(out_valid), 32'd1);
         check({tbl[k].name, "_ctrl"},      32'(ctrl),      32'(tbl[k].ctrl));
         check({tbl[k].name, "_aluop"},     32'(aluop),     32'(tbl[k].aluop));
         check({tbl[k].name, "_ri_exc"},    32'(ri_exc),    32'(tbl[k].ri & RI_ON));
      end

      // DIV then MFLO: MFLO held off for exactly DIV_LAT cycles
      issue("div", I_DIV);
      check("div_md_busy", 32'(md_busy), 32'd1);
      check("div_ctrl",    32'(ctrl),    32'h201);
      cnt = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         inst      = I_MFLO;
         out_ready = 1'b1;
         #1;
         if (in_ready) break;
         if (md_busy) cnt++;
      end
      check("div_busy_cycles", 32'(cnt), 32'd16);
      check("mflo_in_ready",   32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("mflo_ctrl",     32'(ctrl),    32'h00E);
      check("mflo_hiloread", 32'(ctrl[1]), 32'd1);
      check("mflo_md_busy",  32'(md_busy), 32'd0);

      // backpressure holds the output register
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("drain_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid  = 1'b1;
      inst      = I_LW;
      out_ready = 1'b0;
      #1;
      check("bp_empty_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("bp_lw_valid", 32'(out_valid), 32'd1);
      check("bp_lw_ctrl",  32'(ctrl),      32'h058);
      @(negedge clk);
      inst = I_ORI;
      #1;
      check("bp_full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ctrl",  32'(ctrl),      32'h058);
      check("bp_hold_aluop", 32'(aluop),     32'd2);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_ori_ctrl",  32'(ctrl),  32'h048);
      check("bp_ori_aluop", 32'(aluop), 32'd5);

      // flush refuses the offer, empties the stage, leaves the count running
      issue("mult_fl", I_MULT);
      @(negedge clk);
      in_valid  = 1'b1;
      inst      = I_ADD;
      flush     = 1'b1;
      out_ready = 1'b0;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_md_busy",   32'(md_busy),   32'd1);
      flush    = 1'b0;
      in_valid = 1'b0;
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         #1;
         if (!md_busy) break;
         cnt++;
      end
      check("flush_busy_left", 32'(cnt), 32'd3);

      // asynchronous reset in the middle of a divide
      issue("div_rst", I_DIV);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_md_busy",   32'(md_busy),   32'd0);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_ctrl",      32'(ctrl),      32'd0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      in_valid  = 1'b1;
      inst      = I_MFHI;
      out_ready = 1'b1;
      #1;
      check("arst_mfhi_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("arst_mfhi_valid", 32'(out_valid), 32'd1);
      check("arst_mfhi_ctrl",  32'(ctrl),      32'h00E);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/main_dec_pipe.md
MAIN_DEC_PIPE -- requirements
Module: main_dec_pipe

Interface
REQ-001 Parameter CTRL_W, default 10, SHALL set the control-word width; bits 9..0 = {hilowrite, jump, branch, alusrc, memwrite, memtoreg, regwrite, regdst, hiloread, mdstart}, and bits above 9 SHALL be driven 0.
REQ-002 Parameter ALUOP_W, default 4, SHALL set the aluop width; aluop values SHALL be the team's define.vh ALUOP encodings, zero-extended to ALUOP_W.
REQ-003 Parameter MUL_LAT, default 4, SHALL set the multiply busy cycles; parameter DIV_LAT, default 16, SHALL set the divide busy cycles; both SHALL be 1..255.
REQ-004 clk  input  1  the only clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  an instruction is offered on inst.
REQ-007 inst  input  32  MIPS32 instruction; op = inst[31:26], funct = inst[5:0].
REQ-008 in_ready  output  1  the offered instruction is accepted this cycle.
REQ-009 flush  input  1  discard the registered decode result.
REQ-010 out_ready  input  1  the EX stage takes the registered result this cycle.
REQ-011 out_valid  output  1  ctrl, aluop and ri_exc hold a valid decode.
REQ-012 ctrl  output  CTRL_W  registered control word.
REQ-013 aluop  output  ALUOP_W  registered ALU operation.
REQ-014 md_busy  output  1  the multiply/divide unit is occupied.
REQ-015 ri_exc  output  1  reserved-instruction flag, registered with the decode.

Function
REQ-016 Decode SHALL cover the define.vh OP_* set (R-type, andi, ori, xori, lui, addi, addiu, slti, sltiu, beq, bne, bgtz, bltz, bgez, blez, j, lw, sw) with INST_CON_* control values; R-type funct MULT/MULTU/DIV/DIVU SHALL set hilowrite=1 and mdstart=1; MFHI/MFLO SHALL set hiloread=1 and regwrite=1.
REQ-017 Decode SHALL register the result: a handshake in cycle N (in_valid & in_ready) SHALL present out_valid=1 with the result in cycle N+1; latency is 1 cycle.
REQ-018 stage_free SHALL be !out_valid | out_ready; in_ready SHALL be stage_free & !flush & !hazard, computed combinationally.
REQ-019 hazard SHALL be 1 when md_busy=1 and the offered instruction has hiloread=1 or mdstart=1; otherwise 0.
REQ-020 out_valid SHALL be set on an input handshake; otherwise it SHALL be cleared when out_ready=1 or flush=1; otherwise it SHALL hold. ctrl, aluop and ri_exc SHALL hold while out_valid=1 and out_ready=0.
REQ-021 flush SHALL take priority over a simultaneous in_valid, which SHALL be refused; flush SHALL NOT alter the busy counter.
REQ-022 An 8-bit busy counter SHALL load MUL_LAT (MULT/MULTU) or DIV_LAT (DIV/DIVU) when an mdstart instruction handshakes into the output register; otherwise it SHALL decrement by 1 while nonzero; md_busy SHALL equal (counter != 0).
REQ-023 Because of REQ-019, a load SHALL only occur with the counter at 0; the counter SHALL NOT wrap below 0.

Reset
REQ-024 While rst_n=0, out_valid, ctrl, aluop, ri_exc and the counter SHALL be 0 immediately, independent of clk; md_busy SHALL therefore be 0.
REQ-025 Reset during a busy period SHALL abandon the count; the first cycle after release SHALL accept MFHI.

Configuration
REQ-026 With macro MAIN_DEC_RI_EXC_EN defined, an undefined op or R-type funct SHALL decode with ctrl=0 and aluop=0, and SHALL set ri_exc=1.
REQ-027 Without MAIN_DEC_RI_EXC_EN, undefined encodings SHALL decode with ctrl=0 and aluop=0 (a NOP), and ri_exc SHALL be tied to 0.

Verification
REQ-028 Offer lw (op 100011) with out_ready=1 -> next cycle out_valid=1, memtoreg=1, regwrite=1, alusrc=1, define.vh add aluop.
REQ-029 Offer DIV (funct 011010) then MFLO with DIV_LAT=16 -> md_busy high 16 cycles; in_ready=0 for MFLO until the cycle after the counter reaches 0; MFLO then issues with hiloread=1.
REQ-030 Hold out_ready=0 with out_valid=1 and in_valid=1 -> in_ready=0 and outputs stable; on out_ready=1, in_ready=1 in the same cycle.
REQ-031 Assert flush together with in_valid=1 -> in_ready=0, out_valid=0 next cycle, counter unaffected.
REQ-032 Offer op 111111 -> ri_exc=1 and ctrl=0 with MAIN_DEC_RI_EXC_EN defined; ri_exc=0 and ctrl=0 without it.
REQ-033 Drive rst_n=0 mid-DIV with no clk edge -> md_busy=0 and out_valid=0 immediately.
